param_universal_shiftregister: RTL

//   Parametrised universal shift register: WIDTH-bit generalisation of the
//   two-bit shift register, retaining hold / shift-right / shift-left / load

---
 rtl/param_universal_shiftregister.sv | 115 +++++++++++
 1 files changed

// File: rtl/param_universal_shiftregister.sv
`default_nettype none
// ============================================================================
// Module   : param_universal_shiftregister
// Brief    : WIDTH-bit universal shift register (hold/shift/load/rotate/ASR)
//            with multi-step burst shifts under busy/done control.
// Revision : 1.0
// ============================================================================
module param_universal_shiftregister #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  input  logic             rightshift,
  input  logic             leftshift,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] out,
  output logic             so_right,
  output logic             so_left,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_OP_HOLD = 3'b000;
  localparam logic [2:0] c_OP_SHR  = 3'b001;
  localparam logic [2:0] c_OP_SHL  = 3'b010;
  localparam logic [2:0] c_OP_LOAD = 3'b011;
  localparam logic [2:0] c_OP_ROTR = 3'b100;
  localparam logic [2:0] c_OP_ROTL = 3'b101;
  localparam logic [2:0] c_OP_ASR  = 3'b110;

  localparam logic [AMT_W-1:0] c_AMT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;

  logic [WIDTH-1:0] out_q, out_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q,  op_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic             rs,
    input logic             ls,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      c_OP_SHR:  r = {rs, v[WIDTH-1:1]};
      c_OP_SHL:  r = {v[WIDTH-2:0], ls};
      c_OP_LOAD: r = din;
      c_OP_ROTR: r = {v[0], v[WIDTH-1:1]};
      c_OP_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      c_OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:   r = v;
    endcase
    return r;
  endfunction

  // Only the movement ops can be repeated as a burst; hold/load/reserved ignore start.
  function automatic logic f_is_burst_op(input logic [2:0] op);
    return (op == c_OP_SHR) || (op == c_OP_SHL) || (op == c_OP_ROTR) ||
           (op == c_OP_ROTL) || (op == c_OP_ASR);
  endfunction

  logic w_busy;
  assign w_busy = (rem_q != c_AMT_ZERO);

  always_comb begin
    out_d  = out_q;
    rem_d  = rem_q;
    op_d   = op_q;
    done_d = 1'b0;
    if (w_busy) begin
      out_d  = f_apply(op_q, out_q, rightshift, leftshift, in);
      rem_d  = rem_q - c_AMT_ONE;
      done_d = (rem_q == c_AMT_ONE);
    end else if (start && f_is_burst_op(sel)) begin
      op_d   = sel;
      done_d = (amount <= c_AMT_ONE);
      if (amount != c_AMT_ZERO) begin
        out_d = f_apply(sel, out_q, rightshift, leftshift, in);
        rem_d = amount - c_AMT_ONE;
      end
    end else begin
      out_d = f_apply(sel, out_q, rightshift, leftshift, in);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      out_q  <= '0;
      rem_q  <= '0;
      op_q   <= c_OP_HOLD;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      done_q <= done_d;
    end
  end

  assign out      = out_q;
  assign so_right = out_q[0];
  assign so_left  = out_q[WIDTH-1];
  assign busy     = w_busy;
  assign done     = done_q;

endmodule
`default_nettype wire
